// File: rtl/mult8_pkg.sv
// rtl/mult8_pkg.sv - shared constants and state encoding for the 8x8 multiplier library
package mult8_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/acc_sat_add.sv
// rtl/acc_sat_add.sv - combinational unsigned saturating adder
module acc_sat_add
    import mult8_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] full;

    // One extra bit catches the carry out; any carry clamps the result to all-ones.
    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        sat  = full[W];
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/mult8_dot_accum.sv
// rtl/mult8_dot_accum.sv - framed saturating dot-product accumulator behind the 8x8 multiplier
module mult8_dot_accum
    import mult8_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_sat_q, res_sat_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_sat;
    logic               beat;
    logic               first_beat;
    logic               last_beat;

    // A held result only blocks input while the consumer is stalling it.
    assign in_ready   = (state_q != HOLD) || out_ready;
    assign out_valid  = (state_q == HOLD);
    assign out_acc    = res_q;
    assign out_sat    = res_sat_q;

    assign prod_ext   = ACC_W'(in_prod);
    assign beat       = in_valid && in_ready;
    // From HOLD a beat is only possible together with the result handshake.
    assign first_beat = beat && (state_q != ACCUM);
    assign last_beat  = (cnt_q == len_q - LEN_W'(1));

    acc_sat_add #(
        .W   (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Next-state: open a frame on a first beat, accumulate in ACCUM, release HOLD on handshake.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        res_d     = res_q;
        res_sat_d = res_sat_q;

        if (first_beat) begin
            acc_d = prod_ext;
            sat_d = 1'b0;
            len_d = cfg_len;
            cnt_d = '0;
            if (cfg_len == '0) begin
                state_d   = HOLD;
                res_d     = prod_ext;
                res_sat_d = 1'b0;
            end else begin
                state_d   = ACCUM;
            end
        end else if (state_q == ACCUM && beat) begin
            acc_d = add_sum;
            sat_d = sat_q | add_sat;
            cnt_d = cnt_q + LEN_W'(1);
            if (last_beat) begin
                state_d   = HOLD;
                res_d     = add_sum;
                res_sat_d = sat_q | add_sat;
            end
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end

        // Abort drops the open frame, any held result and any beat offered this cycle.
        if (flush) begin
            state_d   = IDLE;
            acc_d     = '0;
            sat_d     = 1'b0;
            cnt_d     = '0;
            res_d     = '0;
            res_sat_d = 1'b0;
        end
    end

    // State, accumulator, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            res_q     <= '0;
            res_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            res_q     <= res_d;
            res_sat_q <= res_sat_d;
        end
    end

endmodule

// File: tb/tb_mult8_dot_accum.sv
// tb/tb_mult8_dot_accum.sv - scoreboard bench for mult8_dot_accum
module tb_mult8_dot_accum;

    localparam int     PROD_W = 16;
    localparam int     ACC_W  = 20;
    localparam int     LEN_W  = 8;
    localparam longint MAXV   = (longint'(1) << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_acc;
    logic              out_sat;

    int                n_checks = 0;
    int                n_fail = 0;
    logic [ACC_W:0]    exp_q[$];
    longint            frame_sum = 0;
    int                frame_left = 0;
    bit                rand_ready_en = 1'b0;

    mult8_dot_accum #(
        .PROD_W    (PROD_W),
        .ACC_W     (ACC_W),
        .LEN_W     (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is cfg_len+1 beats; result is min(total, 2^ACC_W-1), sat when total overflows.
    task automatic model_beat(input logic [PROD_W-1:0] p, input logic [LEN_W-1:0] len);
        logic             s;
        longint           v;
        logic [ACC_W-1:0] a;
        if (frame_left == 0) begin
            frame_left = int'(len) + 1;
            frame_sum  = 0;
        end
        frame_sum += longint'(p);
        frame_left--;
        if (frame_left == 0) begin
            s = (frame_sum > MAXV);
            v = s ? MAXV : frame_sum;
            a = v[ACC_W-1:0];
            exp_q.push_back({s, a});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [PROD_W-1:0] p, input logic [LEN_W-1:0] len);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_prod  = p;
        cfg_len  = len;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(p, len);
                done = 1'b1;
            end
            next_cycle();
        end
        if (!done) check("beat_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Monitor: every result handshake pops and compares the oldest expected frame.
    initial begin
        logic [ACC_W:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got acc=%0d sat=%0b expected no result", out_acc, out_sat);
                end else begin
                    e = exp_q.pop_front();
                    check("result_acc", longint'(out_acc), longint'(e[ACC_W-1:0]));
                    check("result_sat", longint'(out_sat), longint'(e[ACC_W]));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PROD_W-1:0] t4[4];
        longint            t0;
        int                len;
        bit                big;
        logic [PROD_W-1:0] p;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_acc", out_acc, 0);
        check("reset_out_sat", out_sat, 0);

        // Basic frame, one-cycle valid pulse
        out_ready = 1'b1;
        send_beat(16'd100, 8'd2);
        send_beat(16'd200, 8'd2);
        send_beat(16'd300, 8'd2);
        check("t1_valid", out_valid, 1);
        check("t1_acc", out_acc, 600);
        next_cycle();
        check("t1_one_cycle", out_valid, 0);

        // Saturation then clean next frame
        for (int i = 0; i < 17; i++) send_beat(16'hFFFF, 8'd16);
        check("t2_acc", out_acc, MAXV);
        check("t2_sat", out_sat, 1);
        send_beat(16'd5, 8'd0);
        check("t2_next_acc", out_acc, 5);
        check("t2_next_sat", out_sat, 0);
        next_cycle();

        // Backpressure
        out_ready = 1'b0;
        send_beat(16'd10, 8'd1);
        send_beat(16'd20, 8'd1);
        in_valid = 1'b1;
        in_prod  = 16'd50;
        cfg_len  = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_in_ready_low", in_ready, 0);
            check("t3_acc_stable", out_acc, 30);
            check("t3_valid_held", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(16'd50, 8'd0);
        check("t3_same_cycle_accept", out_acc, 50);

        // Full throughput with single-beat frames
        t4[0] = 16'd1;
        t4[1] = 16'd2;
        t4[2] = 16'd3;
        t4[3] = 16'hFFFF;
        t0 = longint'($time);
        for (int i = 0; i < 4; i++) begin
            send_beat(t4[i], 8'd0);
            check("t4_valid", out_valid, 1);
            check("t4_acc", out_acc, longint'(t4[i]));
        end
        check("t4_no_stall", longint'($time) - t0, 40);

        // Flush mid-frame with a beat offered in the flush cycle
        send_beat(16'd7, 8'd3);
        send_beat(16'd8, 8'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_prod  = 16'd1000;
        cfg_len  = 8'd0;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        frame_left = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send_beat(16'd9, 8'd0);
        check("t5_next_acc", out_acc, 9);
        next_cycle();

        // Async reset mid-frame
        send_beat(16'd4, 8'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t6a_out_valid", out_valid, 0);
        check("t6a_out_acc", out_acc, 0);
        check("t6a_in_ready", in_ready, 1);
        frame_left = 0;
        #3 rst_n = 1'b1;
        next_cycle();

        // Async reset while holding a result
        out_ready = 1'b0;
        send_beat(16'd77, 8'd0);
        check("t6b_held", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6b_out_valid", out_valid, 0);
        check("t6b_out_acc", out_acc, 0);
        check("t6b_out_sat", out_sat, 0);
        exp_q.delete();
        frame_left = 0;
        #3 rst_n = 1'b1;
        next_cycle();
        out_ready = 1'b1;
        send_beat(16'd4, 8'd1);
        send_beat(16'd6, 8'd1);
        check("t6_after_acc", out_acc, 10);

        // Randomized frames, gaps, backpressure and mid-frame cfg_len changes
        rand_ready_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            big = ($urandom_range(0, 1) == 1);
            len = big ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 6));
            for (int b = 0; b <= len; b++) begin
                if ($urandom_range(0, 3) == 0) next_cycle();
                p = big ? PROD_W'($urandom_range(16'hC000, 16'hFFFF)) : PROD_W'($urandom);
                send_beat(p, (b == 0) ? LEN_W'(len) : LEN_W'($urandom));
            end
        end

        rand_ready_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) next_cycle();
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
